// File: rtl/issue_select_bank_pkg.sv
// rtl/issue_select_bank_pkg.sv - shared types and helpers for the issue-select bank
package issue_select_bank_pkg;

  typedef enum logic [0:0] {
    ISS_OLDEST = 1'b0,
    ISS_RR     = 1'b1
  } issue_policy_e;

  // RS index width; a one-entry bank still needs a 1-bit index.
  function automatic int rs_idx_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/issue_select_bank_oldest_select.sv
// rtl/issue_select_bank_oldest_select.sv - picks the masked entry with the smallest age
module issue_select_bank_oldest_select #(
  parameter int N     = 8,
  parameter int AGE_W = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]       mask,
  input  logic [N*AGE_W-1:0] ages,
  output logic [N-1:0]       pick,
  output logic               found,
  output logic [IDX_W-1:0]   pick_idx
);

  logic [AGE_W-1:0] best;

  // Strict less-than keeps the lowest index on equal ages.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    best     = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i] && (!found || (ages[i*AGE_W +: AGE_W] < best))) begin
        found    = 1'b1;
        best     = ages[i*AGE_W +: AGE_W];
        pick_idx = IDX_W'(i);
      end
    end
    pick = found ? (N'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/issue_select_bank.sv
// rtl/issue_select_bank.sv - selects up to NUM_FU ready RS entries per cycle into FU issue lanes
module issue_select_bank
  import issue_select_bank_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_FU      = 2,
  parameter int PAYLOAD_W   = 64,
  parameter int ROB_IDX_W   = 5,
  parameter int POLICY      = 0,
  parameter int PERF_W      = 16,
  localparam int IDX_W      = rs_idx_w(NUM_ENTRIES)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [ROB_IDX_W-1:0]             rob_head,
  input  logic [NUM_ENTRIES-1:0]           req_valid,
  input  logic [NUM_ENTRIES*ROB_IDX_W-1:0] req_rob_idx,
  input  logic [NUM_ENTRIES*PAYLOAD_W-1:0] req_payload,
  output logic [NUM_FU-1:0]                clear_valid,
  output logic [NUM_FU*IDX_W-1:0]          clear_idx,
  output logic [NUM_FU-1:0]                iss_valid,
  output logic [NUM_FU*ROB_IDX_W-1:0]      iss_rob_idx,
  output logic [NUM_FU*PAYLOAD_W-1:0]      iss_payload,
  input  logic [NUM_FU-1:0]                fu_ready,
  output logic [PERF_W-1:0]                stall_cnt
);

  localparam int  AGE_W  = (ROB_IDX_W > IDX_W) ? ROB_IDX_W : IDX_W;
  localparam bit  USE_RR = (POLICY == int'(ISS_RR));

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PAYLOAD_W-1:0] payload;
  } lane_t;

  logic [IDX_W-1:0]             rr_ptr;
  logic [IDX_W-1:0]             rr_next;
  logic [NUM_ENTRIES*AGE_W-1:0] ages;
  logic [ROB_IDX_W-1:0]         rob_age;
  int                           rr_dist;

  logic [NUM_ENTRIES-1:0] avail    [NUM_FU+1];
  logic [NUM_ENTRIES-1:0] pick     [NUM_FU];
  logic [IDX_W-1:0]       pick_idx [NUM_FU];
  logic [NUM_FU-1:0]      found;
  logic [NUM_FU-1:0]      grant;

  // Both policies reduce to "smallest age wins"; round-robin measures distance from rr_ptr.
  always_comb begin
    ages    = '0;
    rob_age = '0;
    rr_dist = 0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (USE_RR) begin
        rr_dist = i - int'(rr_ptr);
        if (rr_dist < 0) rr_dist = rr_dist + NUM_ENTRIES;
        ages[i*AGE_W +: AGE_W] = AGE_W'(rr_dist);
      end else begin
        rob_age = req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W] - rob_head;
        ages[i*AGE_W +: AGE_W] = AGE_W'(rob_age);
      end
    end
  end

  assign avail[0] = req_valid;

  for (genvar l = 0; l < NUM_FU; l++) begin : g_lane
    lane_t lane_q;
    logic  lane_free;

    assign lane_free = !lane_q.valid || fu_ready[l];

    issue_select_bank_oldest_select #(
      .N     (NUM_ENTRIES),
      .AGE_W (AGE_W),
      .IDX_W (IDX_W)
    ) u_select (
      .mask     (avail[l]),
      .ages     (ages),
      .pick     (pick[l]),
      .found    (found[l]),
      .pick_idx (pick_idx[l])
    );

    assign grant[l]    = lane_free && found[l] && !flush && reset;
    assign avail[l+1]  = grant[l] ? (avail[l] & ~pick[l]) : avail[l];

    assign clear_valid[l]                   = grant[l];
    assign clear_idx[l*IDX_W +: IDX_W]      = grant[l] ? pick_idx[l] : '0;
    assign iss_valid[l]                     = lane_q.valid;
    assign iss_rob_idx[l*ROB_IDX_W +: ROB_IDX_W] = lane_q.rob_idx;
    assign iss_payload[l*PAYLOAD_W +: PAYLOAD_W] = lane_q.payload;

    always_ff @(posedge clock) begin
      if (!reset) begin
        lane_q <= '0;
      end else if (flush) begin
        lane_q.valid <= 1'b0;
      end else if (grant[l]) begin
        lane_q.valid   <= 1'b1;
        lane_q.rob_idx <= req_rob_idx[int'(pick_idx[l])*ROB_IDX_W +: ROB_IDX_W];
        lane_q.payload <= req_payload[int'(pick_idx[l])*PAYLOAD_W +: PAYLOAD_W];
      end else if (fu_ready[l]) begin
        lane_q.valid <= 1'b0;
      end
    end
  end

  // Highest lane granted holds the last pick in priority order.
  always_comb begin
    rr_next = rr_ptr;
    for (int l = 0; l < NUM_FU; l++) begin
      if (grant[l]) begin
        rr_next = (pick_idx[l] == IDX_W'(NUM_ENTRIES - 1)) ? '0 : pick_idx[l] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      if (|grant) rr_ptr <= rr_next;
      if ((|req_valid) && !(|grant) && !flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_select_bank.sv
// tb/tb_issue_select_bank.sv - self-checking bench for issue_select_bank
module tb_issue_select_bank;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         flush;
  logic [4:0]   rob_head;
  logic [7:0]   req_valid;
  logic [4:0]   rob_a [8];
  logic [63:0]  pay_a [8];
  logic [39:0]  req_rob_idx;
  logic [511:0] req_payload;
  logic [1:0]   clear_valid;
  logic [5:0]   clear_idx;
  logic [1:0]   iss_valid;
  logic [9:0]   iss_rob_idx;
  logic [127:0] iss_payload;
  logic [1:0]   fu_ready;
  logic [15:0]  stall_cnt;

  logic [7:0]   r_req_valid;
  logic [63:0]  r_payload;
  logic [0:0]   r_clear_valid;
  logic [2:0]   r_clear_idx;
  logic [0:0]   r_iss_valid;
  logic [4:0]   r_iss_rob_idx;
  logic [7:0]   r_iss_payload;
  logic [0:0]   r_fu_ready;
  logic [2:0]   r_stall_cnt;

  always_comb begin
    req_rob_idx = '0;
    req_payload = '0;
    for (int e = 0; e < 8; e++) begin
      req_rob_idx[e*5 +: 5]   = rob_a[e];
      req_payload[e*64 +: 64] = pay_a[e];
    end
  end

  issue_select_bank #(
    .NUM_ENTRIES(8), .NUM_FU(2), .PAYLOAD_W(64), .ROB_IDX_W(5), .POLICY(0), .PERF_W(16)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .rob_head(rob_head),
    .req_valid(req_valid), .req_rob_idx(req_rob_idx), .req_payload(req_payload),
    .clear_valid(clear_valid), .clear_idx(clear_idx), .iss_valid(iss_valid),
    .iss_rob_idx(iss_rob_idx), .iss_payload(iss_payload), .fu_ready(fu_ready),
    .stall_cnt(stall_cnt)
  );

  issue_select_bank #(
    .NUM_ENTRIES(8), .NUM_FU(1), .PAYLOAD_W(8), .ROB_IDX_W(5), .POLICY(1), .PERF_W(3)
  ) dut_rr (
    .clock(clock), .reset(reset), .flush(1'b0), .rob_head(5'd0),
    .req_valid(r_req_valid), .req_rob_idx(40'd0), .req_payload(r_payload),
    .clear_valid(r_clear_valid), .clear_idx(r_clear_idx), .iss_valid(r_iss_valid),
    .iss_rob_idx(r_iss_rob_idx), .iss_payload(r_iss_payload), .fu_ready(r_fu_ready),
    .stall_cnt(r_stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  bit          m_valid [2];
  logic [4:0]  m_rob   [2];
  logic [63:0] m_pay   [2];
  logic [15:0] m_stall;
  bit          exp_cv  [2];
  logic [2:0]  exp_ci  [2];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int age_of(input int e);
    return (int'(rob_a[e]) - int'(rob_head) + 32) % 32;
  endfunction

  // Position of entry e in the global oldest-first order among current requesters.
  function automatic int rank_of(input int e);
    int r = 0;
    for (int k = 0; k < 8; k++) begin
      if (req_valid[k] && ((age_of(k) < age_of(e)) || (age_of(k) == age_of(e) && k < e))) r++;
    end
    return r;
  endfunction

  task automatic compute_expect();
    int slot = 0;
    for (int l = 0; l < 2; l++) begin
      exp_cv[l] = 1'b0;
      exp_ci[l] = 3'd0;
    end
    if (reset && !flush) begin
      for (int l = 0; l < 2; l++) begin
        if (!m_valid[l] || fu_ready[l]) begin
          for (int e = 0; e < 8; e++) begin
            if (req_valid[e] && rank_of(e) == slot) begin
              exp_cv[l] = 1'b1;
              exp_ci[l] = 3'(e);
            end
          end
          slot++;
        end
      end
    end
  endtask

  task automatic pre();
    #2;
    compute_expect();
    check("clear_valid", 128'(clear_valid), 128'({exp_cv[1], exp_cv[0]}));
    check("clear_idx", 128'(clear_idx), 128'({exp_ci[1], exp_ci[0]}));
  endtask

  task automatic post();
    if (!reset) begin
      for (int l = 0; l < 2; l++) begin
        m_valid[l] = 1'b0;
        m_rob[l]   = '0;
        m_pay[l]   = '0;
      end
      m_stall = '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (flush) m_valid[l] = 1'b0;
        else if (exp_cv[l]) begin
          m_valid[l] = 1'b1;
          m_rob[l]   = rob_a[exp_ci[l]];
          m_pay[l]   = pay_a[exp_ci[l]];
        end else if (fu_ready[l]) m_valid[l] = 1'b0;
      end
      if ((|req_valid) && !exp_cv[0] && !exp_cv[1] && !flush && m_stall != 16'hffff)
        m_stall = m_stall + 16'd1;
    end
    @(posedge clock);
    #1;
    check("iss_valid", 128'(iss_valid), 128'({m_valid[1], m_valid[0]}));
    check("iss_rob_idx", 128'(iss_rob_idx), 128'({m_rob[1], m_rob[0]}));
    check("iss_payload", iss_payload, {m_pay[1], m_pay[0]});
    check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  logic [63:0] held_pay;
  logic [15:0] stall_before;

  initial begin
    reset = 1'b0; flush = 1'b0; rob_head = '0; req_valid = 8'hff; fu_ready = 2'b11;
    r_req_valid = 8'hff; r_fu_ready = 1'b1;
    for (int e = 0; e < 8; e++) begin
      rob_a[e] = 5'(e);
      pay_a[e] = {$urandom, $urandom};
      r_payload[e*8 +: 8] = 8'(8'h10 + e);
    end
    for (int l = 0; l < 2; l++) begin
      m_valid[l] = 1'b0; m_rob[l] = '0; m_pay[l] = '0;
    end
    m_stall = '0;
    #1;

    // reset held low with requests pending
    cycle();
    cycle();
    check("rst_rr_clear_valid", 128'(r_clear_valid), 128'(0));
    reset = 1'b1; req_valid = 8'h00; r_req_valid = 8'h00;
    check("rst_iss_valid", 128'(iss_valid), 128'(0));
    check("rst_stall_cnt", 128'(stall_cnt), 128'(0));

    // oldest-first with head wrap
    rob_head = 5'd30;
    req_valid = 8'b0101_0010;
    rob_a[1] = 5'd2; rob_a[4] = 5'd31; rob_a[6] = 5'd30;
    pre();
    check("t2_clear_idx", 128'(clear_idx), 128'({3'd4, 3'd6}));
    post();
    check("t2_iss_rob_idx", 128'(iss_rob_idx), 128'({5'd31, 5'd30}));

    // lane0 stalled, lane1 keeps issuing
    req_valid = 8'b0000_1101;
    fu_ready  = 2'b10;
    held_pay  = iss_payload[63:0];
    for (int c = 0; c < 3; c++) begin
      pre();
      check("t3_clear_valid", 128'(clear_valid), 128'(2'b10));
      post();
      check("t3_lane0_payload", 128'(iss_payload[63:0]), 128'(held_pay));
    end

    // flush beats grants
    req_valid = 8'b0011_0000;
    fu_ready  = 2'b11;
    flush     = 1'b1;
    pre();
    check("t4_clear_valid", 128'(clear_valid), 128'(0));
    post();
    check("t4_iss_valid", 128'(iss_valid), 128'(0));
    flush = 1'b0;

    // fill both lanes, then stall them for 5 cycles
    req_valid = 8'b1111_0000;
    cycle();
    fu_ready = 2'b00;
    stall_before = stall_cnt;
    for (int c = 0; c < 5; c++) cycle();
    check("t6_stall_delta", 128'(stall_cnt - stall_before), 128'(5));

    // randomized traffic, with one mid-run reset
    for (int k = 0; k < 300; k++) begin
      rob_head  = 5'($urandom);
      req_valid = 8'($urandom);
      fu_ready  = 2'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = (k != 150);
      for (int e = 0; e < 8; e++) begin
        rob_a[e] = 5'($urandom_range(0, 7) + 5'(rob_head));
        pay_a[e] = {$urandom, $urandom};
      end
      cycle();
    end
    reset = 1'b1; flush = 1'b0; req_valid = 8'h00; fu_ready = 2'b11;

    // round-robin wrap on the single-lane instance
    r_req_valid = 8'hff;
    r_fu_ready  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pre();
      check("t5_rr_grant", 128'({r_clear_valid, r_clear_idx}), 128'({1'b1, 3'(i % 8)}));
      post();
    end
    check("t5_rr_payload", 128'(r_iss_payload), 128'(8'h10));

    // stalled lane: counter climbs then saturates
    r_fu_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      pre();
      check("t6_rr_no_grant", 128'(r_clear_valid), 128'(0));
      post();
    end
    check("t6_rr_stall5", 128'(r_stall_cnt), 128'(5));
    for (int c = 0; c < 4; c++) cycle();
    check("t6_rr_sat", 128'(r_stall_cnt), 128'(3'b111));
    cycle();
    check("t6_rr_sat_hold", 128'(r_stall_cnt), 128'(3'b111));
    check("t6_rr_hold_payload", 128'(r_iss_payload), 128'(8'h10));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
